multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Main control FSM for the multicycle RV32I-subset core (lw, sw, R-type, I-type ALU, beq, jal).
- Shares one memory port and one ALU across all instruction phases.
- Drives every mux select and write enable of the datapath from `op`/`funct3`/`funct7b5`/`Zero`.
- Sits beside the datapath inside `top` and exposes a retired-instruction counter for bench checking.

Parameters:
CNT_W, 32, width of InstrRetired counter (wraps modulo 2^CNT_W)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = in reset)
op  input  7  Instr[6:0]
funct3  input  3  Instr[14:12]
funct7b5  input  1  Instr[30]
Zero  input  1  ALU zero flag
PCWrite  output  1  PC register enable
AdrSrc  output  1  memory address select (0 PC, 1 ALUOut)
MemWrite  output  1  data memory write enable
IRWrite  output  1  instruction/OldPC register enable
ResultSrc  output  2  00 ALUOut, 01 Data, 10 ALUResult
ALUSrcA  output  2  00 PC, 01 OldPC, 10 RD1
ALUSrcB  output  2  00 RD2, 01 ImmExt, 10 constant 4
ImmSrc  output  2  00 I, 01 S, 10 B, 11 J
RegWrite  output  1  register file write enable
ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
State  output  4  current state code (debug)
InstrRetired  output  CNT_W  completed-instruction count

Behaviour:
- Reset (reset=0, asynchronous): state=S0, InstrRetired=0.
  - While reset=0: PCWrite, IRWrite, MemWrite, RegWrite forced 0; other outputs take S0 values.
- Reset deassert: first rising edge with reset=1 executes Fetch.
- Outputs are Moore decodes of state, except PCWrite = (Branch & Zero) | PCUpdate.
- ImmSrc is decoded from op in all states: lw/I-type 00, sw 01, beq 10, jal 11, other 00.
- Unlisted outputs default to 0.
- States (code: name: asserted outputs -> next state):
  - 0 Fetch: AdrSrc=0, IRWrite, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate -> 1
  - 1 Decode: ALUSrcA=01, ALUSrcB=01, ALUOp=00 -> next state by op:
    - 0000011 or 0100011 -> 2
    - 0110011 -> 6
    - 0010011 -> 8
    - 1101111 -> 9
    - 1100011 -> 10
    - any other op -> 0 (illegal; no write enables; not counted)
  - 2 MemAdr: ALUSrcA=10, ALUSrcB=01, ALUOp=00 -> 3 if op=0000011, else 5
  - 3 MemRead: ResultSrc=00, AdrSrc=1 -> 4
  - 4 MemWB: ResultSrc=01, RegWrite -> 0
  - 5 MemWr: ResultSrc=00, AdrSrc=1, MemWrite -> 0
  - 6 ExecuteR: ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> 7
  - 7 ALUWB: ResultSrc=00, RegWrite -> 0
  - 8 ExecuteI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> 7
  - 9 JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate -> 7
  - 10 BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch -> 0
  - codes 11-15: unreachable; treated as S0 next cycle (next=0, all enables 0).
- ALU decode (ALUOp is internal):
  - 00 -> add; 01 -> sub.
  - 10 by funct3:
    - 000 -> sub if (op[5] & funct7b5), else add
    - 010 -> slt
    - 110 -> or
    - 111 -> and
    - other -> add
- Latency in cycles: lw 5, sw 4, R 4, I 4, jal 4, beq 3, illegal 2.
- InstrRetired increments by 1 on each clock edge leaving S4, S5, S7 or S10; wraps all-ones -> 0.
- Reset mid-instruction: abandons the instruction immediately; no partial write is issued after reset asserts.

Optional Feature:
MEM_WAIT_EN
- Defined: adds input MemReady (1 bit). In S0, S3 and S5 the FSM holds until MemReady=1.
  - S0: IRWrite and PCUpdate are gated by MemReady, so PC advances exactly once.
  - S5: MemWrite stays asserted for every wait cycle.
  - InstrRetired counts only on actual exit from S5.
- Undefined: no MemReady port; behaves as MemReady tied to 1; latencies as above.

Test Plan:
- Release reset at 22 ns (10 ns clock), feed lw (op=0000011) -> State 0,1,2,3,4,0; RegWrite=1 only in S4; InstrRetired 0->1.
- sw (op=0100011) -> State 0,1,2,5,0; MemWrite=1 exactly one cycle with AdrSrc=1, ImmSrc=01.
- R-type sub (funct3=000, funct7b5=1, op[5]=1) -> ALUControl=001 in S6; I-type addi with funct7b5=1 -> ALUControl=000.
- beq with Zero=1 -> PCWrite=1 in S10; with Zero=0 -> PCWrite=0; both retire in 3 cycles.
- Illegal op=0000000 -> S0,S1,S0; no write enables; InstrRetired unchanged. Assert reset in S3 -> State=0 and all enables 0 asynchronously.
- MEM_WAIT_EN, sw with MemReady low for 3 cycles in S5 -> MemWrite high for 4 cycles; exactly one retire; PC advances once per Fetch.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: control bus between the multicycle datapath and its controller.
// MEM_WAIT_EN adds the MemReady handshake input.
interface multicycle_controller_if #(parameter int CNT_W = 32);
  logic [6:0] op;
  logic [2:0] funct3;
  logic funct7b5;
  logic Zero;
`ifdef MEM_WAIT_EN
  logic MemReady;
`endif
  logic PCWrite;
  logic AdrSrc;
  logic MemWrite;
  logic IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic RegWrite;
  logic [2:0] ALUControl;
  logic [3:0] State;
  logic [CNT_W-1:0] InstrRetired;
  modport master (
`ifdef MEM_WAIT_EN
    output MemReady,
`endif
    output op, funct3, funct7b5, Zero,
    input PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc,
    input RegWrite, ALUControl, State, InstrRetired
  );
  modport slave (
`ifdef MEM_WAIT_EN
    input MemReady,
`endif
    input op, funct3, funct7b5, Zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc,
    output RegWrite, ALUControl, State, InstrRetired
  );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: main FSM of the multicycle RV32I-subset core with retired-instruction counter.
// MEM_WAIT_EN makes Fetch, MemRead and MemWr wait for MemReady.
module multicycle_controller #(
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic reset,
  multicycle_controller_if.slave bus
);
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXR    = 4'd6,
    S_ALUWB  = 4'd7,
    S_EXI    = 4'd8,
    S_JAL    = 4'd9,
    S_BEQ    = 4'd10
  } state_t;
  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011, OP_JAL = 7'b1101111, OP_BEQ = 7'b1100011;
  state_t state, next;
  logic ready, retire, branch, pc_update, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, src_a, src_b, alu_op, imm_src;
  logic [2:0] alu_r, alu_ctl;
  logic [CNT_W-1:0] retired;
`ifdef MEM_WAIT_EN
  assign ready = bus.MemReady;
`else
  assign ready = 1'b1;
`endif
  assign retire = state == S_MEMWB || state == S_ALUWB || state == S_BEQ || (state == S_MEMWR && ready);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_FETCH;
      retired <= '0;
    end else begin
      state <= next;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end
  always_comb begin
    next = S_FETCH;
    adr_src = 1'b0;
    mem_write = 1'b0;
    ir_write = 1'b0;
    reg_write = 1'b0;
    result_src = 2'b00;
    src_a = 2'b00;
    src_b = 2'b00;
    alu_op = 2'b00;
    branch = 1'b0;
    pc_update = 1'b0;
    case (state)
      S_FETCH: begin
        src_b = 2'b10;
        result_src = 2'b10;
        ir_write = ready;
        pc_update = ready;
        next = ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        src_a = 2'b01;
        src_b = 2'b01;
        next = (bus.op == OP_LW || bus.op == OP_SW) ? S_MEMADR :
               bus.op == OP_R   ? S_EXR :
               bus.op == OP_I   ? S_EXI :
               bus.op == OP_JAL ? S_JAL :
               bus.op == OP_BEQ ? S_BEQ : S_FETCH;
      end
      S_MEMADR: begin
        src_a = 2'b10;
        src_b = 2'b01;
        next = bus.op == OP_LW ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        adr_src = 1'b1;
        next = ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write = 1'b1;
      end
      S_MEMWR: begin
        adr_src = 1'b1;
        mem_write = 1'b1;
        next = ready ? S_FETCH : S_MEMWR;
      end
      S_EXR: begin
        src_a = 2'b10;
        alu_op = 2'b10;
        next = S_ALUWB;
      end
      S_ALUWB: reg_write = 1'b1;
      S_EXI: begin
        src_a = 2'b10;
        src_b = 2'b01;
        alu_op = 2'b10;
        next = S_ALUWB;
      end
      S_JAL: begin
        src_a = 2'b01;
        src_b = 2'b10;
        pc_update = 1'b1;
        next = S_ALUWB;
      end
      S_BEQ: begin
        src_a = 2'b10;
        alu_op = 2'b01;
        branch = 1'b1;
      end
      default: ;
    endcase
  end
  always_comb begin
    case (bus.funct3)
      3'b000: alu_r = (bus.op[5] & bus.funct7b5) ? 3'b001 : 3'b000;
      3'b010: alu_r = 3'b101;
      3'b110: alu_r = 3'b011;
      3'b111: alu_r = 3'b010;
      default: alu_r = 3'b000;
    endcase
  end
  assign alu_ctl = alu_op == 2'b01 ? 3'b001 : alu_op == 2'b10 ? alu_r : 3'b000;
  assign imm_src = bus.op == OP_SW ? 2'b01 : bus.op == OP_BEQ ? 2'b10 : bus.op == OP_JAL ? 2'b11 : 2'b00;
  // Write enables are gated by reset so nothing fires while S0 is forced.
  assign bus.PCWrite = reset & ((branch & bus.Zero) | pc_update);
  assign bus.IRWrite = reset & ir_write;
  assign bus.MemWrite = reset & mem_write;
  assign bus.RegWrite = reset & reg_write;
  assign bus.AdrSrc = adr_src;
  assign bus.ResultSrc = result_src;
  assign bus.ALUSrcA = src_a;
  assign bus.ALUSrcB = src_b;
  assign bus.ImmSrc = imm_src;
  assign bus.ALUControl = alu_ctl;
  assign bus.State = state;
  assign bus.InstrRetired = retired;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed and random instruction streams checked against a per-instruction path model.
module tb_multicycle_controller;
  localparam int CNT_W = 32;
  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, JAL = 7'b1101111, BEQ = 7'b1100011;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int total = 0, passed = 0;
  int unsigned retired = 0;
  multicycle_controller_if #(.CNT_W(CNT_W)) bus();
  multicycle_controller #(.CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  function automatic logic [2:0] exp_alu(input logic [6:0] op, input logic [2:0] f3, input logic f7, input int i);
    if (i != 2) return 3'b000;
    if (op == BEQ) return 3'b001;
    if (op != RT && op != IT) return 3'b000;
    case (f3)
      3'b000: return (op == RT && f7) ? 3'b001 : 3'b000;
      3'b010: return 3'b101;
      3'b110: return 3'b011;
      3'b111: return 3'b010;
      default: return 3'b000;
    endcase
  endfunction
  // Runs one instruction from Fetch; ncyc >= 0 stops early, leaving the FSM mid-instruction.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7, input int zmode, input int ncyc);
    logic [3:0] path[$];
    logic legal, z, pcw, irw, mw, rw, adr;
    logic [1:0] imm;
    path = {4'd0, 4'd1};
    legal = 1'b1;
    case (op)
      LW: begin path.push_back(4'd2); path.push_back(4'd3); path.push_back(4'd4); end
      SW: begin path.push_back(4'd2); path.push_back(4'd5); end
      RT: begin path.push_back(4'd6); path.push_back(4'd7); end
      IT: begin path.push_back(4'd8); path.push_back(4'd7); end
      JAL: begin path.push_back(4'd9); path.push_back(4'd7); end
      BEQ: path.push_back(4'd10);
      default: legal = 1'b0;
    endcase
    imm = op == SW ? 2'b01 : op == BEQ ? 2'b10 : op == JAL ? 2'b11 : 2'b00;
    bus.op = op;
    bus.funct3 = f3;
    bus.funct7b5 = f7;
    for (int i = 0; i < path.size(); i++) begin
      if (ncyc >= 0 && i >= ncyc) return;
      z = zmode < 0 ? 1'($urandom) : 1'(zmode);
      bus.Zero = z;
      #2;
      pcw = i == 0 || (op == JAL && i == 2) || (op == BEQ && i == 2 && z);
      irw = i == 0;
      mw = op == SW && i == 3;
      rw = legal && op != SW && op != BEQ && i == path.size() - 1;
      adr = (op == LW || op == SW) && i == 3;
      chk("state", 32'(bus.State), 32'(path[i]));
      chk("enables", {bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite}, {pcw, irw, mw, rw});
      chk("adr_src", 32'(bus.AdrSrc), 32'(adr));
      chk("imm_src", 32'(bus.ImmSrc), 32'(imm));
      chk("alu_control", 32'(bus.ALUControl), 32'(exp_alu(op, f3, f7, i)));
      chk("retired", bus.InstrRetired, retired);
      @(posedge clk);
      #1;
    end
    if (legal) retired++;
  endtask
  initial begin
    logic [6:0] ops[7];
    logic [6:0] o;
    ops = '{LW, SW, RT, IT, JAL, BEQ, 7'b0000000};
`ifdef MEM_WAIT_EN
    bus.MemReady = 1'b1;
`endif
    bus.op = LW;
    bus.funct3 = 3'b000;
    bus.funct7b5 = 1'b0;
    bus.Zero = 1'b0;
    #10;
    chk("rst_state", 32'(bus.State), 32'd0);
    chk("rst_enables", {bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite}, 32'd0);
    chk("rst_retired", bus.InstrRetired, 32'd0);
    chk("rst_alu_src_b", 32'(bus.ALUSrcB), 32'd2);
    chk("rst_result_src", 32'(bus.ResultSrc), 32'd2);
    #12;
    reset = 1'b1;
    run_instr(LW, 3'($urandom), 1'($urandom), -1, -1);
    run_instr(SW, 3'($urandom), 1'($urandom), -1, -1);
    run_instr(RT, 3'b000, 1'b1, -1, -1);
    run_instr(IT, 3'b000, 1'b1, -1, -1);
    run_instr(BEQ, 3'($urandom), 1'($urandom), 1, -1);
    run_instr(BEQ, 3'($urandom), 1'($urandom), 0, -1);
    run_instr(JAL, 3'($urandom), 1'($urandom), -1, -1);
    run_instr(7'b0000000, 3'($urandom), 1'($urandom), -1, -1);
    run_instr(LW, 3'($urandom), 1'($urandom), -1, 3);
    #1;
    chk("pre_reset_state", 32'(bus.State), 32'd3);
    reset = 1'b0;
    #1;
    retired = 0;
    chk("async_state", 32'(bus.State), 32'd0);
    chk("async_enables", {bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite}, 32'd0);
    chk("async_retired", bus.InstrRetired, 32'd0);
    #1;
    reset = 1'b1;
    for (int n = 0; n < 60; n++) begin
      o = ops[$urandom_range(0, 6)];
      if (o == 7'b0000000) begin
        o = 7'($urandom);
        if (o == LW || o == SW || o == RT || o == IT || o == JAL || o == BEQ) o = 7'b1111111;
      end
      run_instr(o, 3'($urandom), 1'($urandom), -1, -1);
    end
    #2;
    chk("final_retired", bus.InstrRetired, retired);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
